xpe_obuf_writer: RTL and testbench

- Sits directly downstream of XPE. Consumes its 256-bit post-processed output beats (o_xpe_data_out / o_xpe_data_valid) and writes them into the IO buffer.
- Generates IO-buffer write addresses over a rows × pieces layout.
- Absorbs IO-buffer port contention with a small FIFO, because XPE has no backpressure.
- Signals completion to the scheduler when the programmed beat count has been written.

---
 rtl/npu_pkg.sv | 14 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/xpe_obuf_writer.sv | 191 +++++++++++++++++++
 tb/tb_xpe_obuf_writer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared NPU constants and the output-writer FSM state type.
package npu_pkg;

   localparam int unsigned XPE_OUT_W    = 256;
   localparam int unsigned IOBUF_ADDR_W = 12;
   localparam int unsigned CNT_W        = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational read data and full/empty flags.
// The caller must not push when full unless it pops in the same cycle.
module sync_fifo #(
   parameter int unsigned DATA_W = 256,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic [DATA_W-1:0] i_data,
   output logic [DATA_W-1:0] o_data_c,
   output logic              o_full_c,
   output logic              o_empty_c
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign o_empty_c = (wr_ptr_q == rd_ptr_q);
   assign o_full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign o_data_c  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (i_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = i_data;
         wr_ptr_d                = wr_ptr_q + PTR_ONE;
      end
      if (i_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/xpe_obuf_writer.sv
// Writes XPE output beats into the IO buffer over a rows x pieces address
// layout, absorbing write-port contention in a skid FIFO.
module xpe_obuf_writer
   import npu_pkg::*;
#(
   parameter int unsigned DATA_W     = XPE_OUT_W,
   parameter int unsigned ADDR_W     = IOBUF_ADDR_W,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_addr_start,
   input  logic [7:0]        i_out_piece,
   input  logic [7:0]        i_row_num,
   input  logic [ADDR_W-1:0] i_row_stride,
   input  logic [DATA_W-1:0] i_xpe_data,
   input  logic              i_xpe_valid,
   input  logic              i_buf_gnt,
   output logic              o_buf_wr_en,
   output logic [ADDR_W-1:0] o_buf_addr,
   output logic [DATA_W-1:0] o_buf_wdata,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_overflow,
   output logic              o_err_stray
);

   state_e            state_q, state_d;

   logic [7:0]        out_piece_q, out_piece_d;
   logic [ADDR_W-1:0] stride_q, stride_d;
   logic [CNT_W-1:0]  total_q, total_d;
   logic [ADDR_W-1:0] row_base_q, row_base_d;
   logic [7:0]        piece_cnt_q, piece_cnt_d;
   logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
   logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;

   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              ovf_q, ovf_d;
   logic              stray_q, stray_d;

   logic              push_c;
   logic              pop_c;
   logic [DATA_W-1:0] fifo_rdata_c;
   logic              fifo_full_c;
   logic              fifo_empty_c;

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (push_c),
      .i_pop     (pop_c),
      .i_data    (i_xpe_data),
      .o_data_c  (fifo_rdata_c),
      .o_full_c  (fifo_full_c),
      .o_empty_c (fifo_empty_c)
   );

   assign pop_c = (state_q == RUN) && !fifo_empty_c && i_buf_gnt;

   // Next-state, counters, address generation and registered outputs.
   always_comb begin
      state_d     = state_q;
      out_piece_d = out_piece_q;
      stride_d    = stride_q;
      total_d     = total_q;
      row_base_d  = row_base_q;
      piece_cnt_d = piece_cnt_q;
      in_cnt_d    = in_cnt_q;
      wr_cnt_d    = wr_cnt_q;
      wr_en_d     = 1'b0;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      done_d      = (state_q == DONE);
      ovf_d       = ovf_q;
      stray_d     = stray_q;
      push_c      = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_start) begin
               out_piece_d = i_out_piece;
               stride_d    = i_row_stride;
               total_d     = CNT_W'(i_out_piece) * CNT_W'(i_row_num);
               row_base_d  = i_addr_start;
               piece_cnt_d = '0;
               in_cnt_d    = '0;
               wr_cnt_d    = '0;
               ovf_d       = 1'b0;
               stray_d     = 1'b0;
               state_d     = (total_d == '0) ? DONE : RUN;
            end
            if (i_xpe_valid) begin
               stray_d = 1'b1;
            end
         end

         RUN: begin
            if (i_xpe_valid) begin
               if (in_cnt_q == total_q) begin
                  stray_d = 1'b1;
               end else if (fifo_full_c && !pop_c) begin
                  ovf_d = 1'b1;
               end else begin
                  push_c   = 1'b1;
                  in_cnt_d = in_cnt_q + CNT_W'(1);
               end
            end
            if (pop_c) begin
               wr_en_d  = 1'b1;
               addr_d   = row_base_q + ADDR_W'(piece_cnt_q);
               wdata_d  = fifo_rdata_c;
               wr_cnt_d = wr_cnt_q + CNT_W'(1);
               if (piece_cnt_q == out_piece_q - 8'd1) begin
                  piece_cnt_d = '0;
                  row_base_d  = row_base_q + stride_q;
               end else begin
                  piece_cnt_d = piece_cnt_q + 8'd1;
               end
               if (wr_cnt_d == total_q) begin
                  state_d = DONE;
               end
            end
         end

         DONE: begin
            if (i_xpe_valid) begin
               stray_d = 1'b1;
            end
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         out_piece_q <= '0;
         stride_q    <= '0;
         total_q     <= '0;
         row_base_q  <= '0;
         piece_cnt_q <= '0;
         in_cnt_q    <= '0;
         wr_cnt_q    <= '0;
         wr_en_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ovf_q       <= 1'b0;
         stray_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_piece_q <= out_piece_d;
         stride_q    <= stride_d;
         total_q     <= total_d;
         row_base_q  <= row_base_d;
         piece_cnt_q <= piece_cnt_d;
         in_cnt_q    <= in_cnt_d;
         wr_cnt_q    <= wr_cnt_d;
         wr_en_q     <= wr_en_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ovf_q       <= ovf_d;
         stray_q     <= stray_d;
      end
   end

   assign o_buf_wr_en = wr_en_q;
   assign o_buf_addr  = addr_q;
   assign o_buf_wdata = wdata_q;
   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_overflow  = ovf_q;
   assign o_err_stray = stray_q;

endmodule

// File: tb/tb_xpe_obuf_writer.sv
// Directed bench for xpe_obuf_writer: layout, latency, contention, overflow,
// zero-size layers, address wrap, reset abort and stray beats.
module tb_xpe_obuf_writer;

   localparam int unsigned DW = 256;
   localparam int unsigned AW = 12;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_start = 1'b0;
   logic [AW-1:0] i_addr_start = '0;
   logic [7:0]    i_out_piece = '0;
   logic [7:0]    i_row_num = '0;
   logic [AW-1:0] i_row_stride = '0;
   logic [DW-1:0] i_xpe_data = '0;
   logic          i_xpe_valid = 1'b0;
   logic          i_buf_gnt = 1'b0;
   logic          o_buf_wr_en;
   logic [AW-1:0] o_buf_addr;
   logic [DW-1:0] o_buf_wdata;
   logic          o_busy;
   logic          o_done;
   logic          o_overflow;
   logic          o_err_stray;

   int nchk  = 0;
   int npass = 0;

   xpe_obuf_writer #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_start      (i_start),
      .i_addr_start (i_addr_start),
      .i_out_piece  (i_out_piece),
      .i_row_num    (i_row_num),
      .i_row_stride (i_row_stride),
      .i_xpe_data   (i_xpe_data),
      .i_xpe_valid  (i_xpe_valid),
      .i_buf_gnt    (i_buf_gnt),
      .o_buf_wr_en  (o_buf_wr_en),
      .o_buf_addr   (o_buf_addr),
      .o_buf_wdata  (o_buf_wdata),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_overflow   (o_overflow),
      .o_err_stray  (o_err_stray)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Write / done log, sampled on the falling edge.
   logic [AW-1:0] wa_q [$];
   logic [DW-1:0] wd_q [$];
   int            wc_q [$];
   int            done_cnt = 0;
   int            done_cyc = 0;
   int            overlap  = 0;

   always @(negedge clk) begin
      if (o_buf_wr_en) begin
         wa_q.push_back(o_buf_addr);
         wd_q.push_back(o_buf_wdata);
         wc_q.push_back(cyc);
      end
      if (o_done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
         if (o_buf_wr_en) overlap = overlap + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_layer(input logic [AW-1:0] a, input logic [7:0] p,
                              input logic [7:0] r, input logic [AW-1:0] s);
      i_addr_start = a; i_out_piece = p; i_row_num = r; i_row_stride = s;
      i_start = 1'b1;
      step();
      i_start = 1'b0;
   endtask

   task automatic beat(input logic [DW-1:0] d);
      i_xpe_valid = 1'b1;
      i_xpe_data  = d;
      step();
      i_xpe_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; i_start = 1'b0; i_xpe_valid = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      nchk++; if ({o_buf_wr_en, o_busy, o_done, o_overflow, o_err_stray} !== 5'b0)
         $display("FAIL reset_flags: got %b expected 00000", {o_buf_wr_en, o_busy, o_done, o_overflow, o_err_stray}); else npass++;
      nchk++; if (o_buf_addr !== '0) $display("FAIL reset_addr: got %h expected 000", o_buf_addr); else npass++;
      nchk++; if (o_buf_wdata !== '0) $display("FAIL reset_wdata: got %h expected 0", o_buf_wdata); else npass++;
   endtask

   task automatic test_basic();
      logic [AW-1:0] ea [6] = '{12'h010, 12'h011, 12'h012, 12'h030, 12'h031, 12'h032};
      int w0 = wa_q.size();
      int d0 = done_cnt;
      int v0;
      i_buf_gnt = 1'b1;
      start_layer(12'h010, 8'd3, 8'd2, 12'h020);
      nchk++; if (o_busy !== 1'b1) $display("FAIL basic_busy: got %b expected 1", o_busy); else npass++;
      v0 = cyc;
      for (int i = 0; i < 6; i++) beat(DW'(i + 1));
      for (int k = 0; k < 40 && done_cnt == d0; k++) step();
      nchk++; if (done_cnt - d0 != 1) $display("FAIL basic_done_cnt: got %0d expected 1", done_cnt - d0); else npass++;
      nchk++; if (wa_q.size() - w0 != 6) $display("FAIL basic_wr_cnt: got %0d expected 6", wa_q.size() - w0); else npass++;
      if (wa_q.size() - w0 == 6) begin
         for (int i = 0; i < 6; i++) begin
            nchk++; if (wa_q[w0+i] !== ea[i]) $display("FAIL basic_addr%0d: got %h expected %h", i, wa_q[w0+i], ea[i]); else npass++;
            nchk++; if (wd_q[w0+i] !== DW'(i + 1)) $display("FAIL basic_data%0d: got %0h expected %0h", i, wd_q[w0+i], i + 1); else npass++;
         end
         nchk++; if (wc_q[w0] != v0 + 2) $display("FAIL basic_latency: got %0d expected %0d", wc_q[w0] - v0, 2); else npass++;
         nchk++; if (done_cyc != wc_q[w0+5] + 1) $display("FAIL basic_done_cycle: got %0d expected %0d", done_cyc, wc_q[w0+5] + 1); else npass++;
      end
      nchk++; if (overlap != 0) $display("FAIL basic_overlap: got %0d expected 0", overlap); else npass++;
      nchk++; if (o_overflow !== 1'b0) $display("FAIL basic_ovf: got %b expected 0", o_overflow); else npass++;
      nchk++; if (o_busy !== 1'b0) $display("FAIL basic_busy_end: got %b expected 0", o_busy); else npass++;
   endtask

   task automatic test_contention();
      logic [AW-1:0] ea [6] = '{12'h010, 12'h011, 12'h012, 12'h030, 12'h031, 12'h032};
      int w0 = wa_q.size();
      int d0 = done_cnt;
      i_buf_gnt = 1'b0;
      start_layer(12'h010, 8'd3, 8'd2, 12'h020);
      for (int i = 0; i < 4; i++) beat(DW'(8'hA1 + i));
      nchk++; if (dut.u_fifo.o_full_c !== 1'b1) $display("FAIL cont_full: got %b expected 1", dut.u_fifo.o_full_c); else npass++;
      nchk++; if (wa_q.size() != w0) $display("FAIL cont_no_write: got %0d expected 0", wa_q.size() - w0); else npass++;
      i_buf_gnt = 1'b1;
      beat(DW'(8'hA5));
      beat(DW'(8'hA6));
      for (int k = 0; k < 40 && done_cnt == d0; k++) step();
      nchk++; if (done_cnt - d0 != 1) $display("FAIL cont_done: got %0d expected 1", done_cnt - d0); else npass++;
      nchk++; if (wa_q.size() - w0 != 6) $display("FAIL cont_wr_cnt: got %0d expected 6", wa_q.size() - w0); else npass++;
      if (wa_q.size() - w0 == 6) begin
         for (int i = 0; i < 6; i++) begin
            nchk++; if (wa_q[w0+i] !== ea[i] || wd_q[w0+i] !== DW'(8'hA1 + i))
               $display("FAIL cont_wr%0d: got %h/%0h expected %h/%0h", i, wa_q[w0+i], wd_q[w0+i], ea[i], 8'hA1 + i); else npass++;
         end
      end
      nchk++; if (o_overflow !== 1'b0) $display("FAIL cont_ovf: got %b expected 0", o_overflow); else npass++;
   endtask

   task automatic test_overflow();
      logic [AW-1:0] ea [6] = '{12'h010, 12'h011, 12'h012, 12'h030, 12'h031, 12'h032};
      logic [7:0]    ed [6] = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB6, 8'hB7};
      int w0 = wa_q.size();
      int d0 = done_cnt;
      i_buf_gnt = 1'b0;
      start_layer(12'h010, 8'd3, 8'd2, 12'h020);
      for (int i = 0; i < 5; i++) beat(DW'(8'hB1 + i));
      nchk++; if (o_overflow !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", o_overflow); else npass++;
      i_buf_gnt = 1'b1;
      for (int k = 0; k < 8; k++) step();
      nchk++; if (wa_q.size() - w0 != 4) $display("FAIL ovf_wr_cnt: got %0d expected 4", wa_q.size() - w0); else npass++;
      nchk++; if (done_cnt != d0) $display("FAIL ovf_early_done: got %0d expected 0", done_cnt - d0); else npass++;
      nchk++; if (o_busy !== 1'b1) $display("FAIL ovf_busy: got %b expected 1", o_busy); else npass++;
      beat(DW'(8'hB6));
      beat(DW'(8'hB7));
      for (int k = 0; k < 40 && done_cnt == d0; k++) step();
      nchk++; if (done_cnt - d0 != 1) $display("FAIL ovf_done: got %0d expected 1", done_cnt - d0); else npass++;
      nchk++; if (wa_q.size() - w0 != 6) $display("FAIL ovf_total_wr: got %0d expected 6", wa_q.size() - w0); else npass++;
      if (wa_q.size() - w0 == 6) begin
         for (int i = 0; i < 6; i++) begin
            nchk++; if (wa_q[w0+i] !== ea[i] || wd_q[w0+i] !== DW'(ed[i]))
               $display("FAIL ovf_wr%0d: got %h/%0h expected %h/%0h", i, wa_q[w0+i], wd_q[w0+i], ea[i], ed[i]); else npass++;
         end
      end
      nchk++; if (o_overflow !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", o_overflow); else npass++;
   endtask

   task automatic test_zero();
      int w0 = wa_q.size();
      start_layer(12'h100, 8'd0, 8'd2, 12'h010);
      nchk++; if ({o_busy, o_done} !== 2'b00) $display("FAIL zero_s1: got %b expected 00", {o_busy, o_done}); else npass++;
      step();
      nchk++; if ({o_busy, o_done} !== 2'b01) $display("FAIL zero_s2: got %b expected 01", {o_busy, o_done}); else npass++;
      step();
      nchk++; if ({o_busy, o_done} !== 2'b00) $display("FAIL zero_s3: got %b expected 00", {o_busy, o_done}); else npass++;
      nchk++; if (wa_q.size() != w0) $display("FAIL zero_writes: got %0d expected 0", wa_q.size() - w0); else npass++;
   endtask

   task automatic test_wrap();
      logic [AW-1:0] ea [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
      int w0 = wa_q.size();
      int d0 = done_cnt;
      i_buf_gnt = 1'b1;
      start_layer(12'hFFE, 8'd4, 8'd1, 12'h005);
      for (int i = 0; i < 4; i++) beat(DW'(8'hC0 + i));
      for (int k = 0; k < 40 && done_cnt == d0; k++) step();
      nchk++; if (wa_q.size() - w0 != 4) $display("FAIL wrap_wr_cnt: got %0d expected 4", wa_q.size() - w0); else npass++;
      if (wa_q.size() - w0 == 4) begin
         for (int i = 0; i < 4; i++) begin
            nchk++; if (wa_q[w0+i] !== ea[i]) $display("FAIL wrap_addr%0d: got %h expected %h", i, wa_q[w0+i], ea[i]); else npass++;
         end
      end
   endtask

   task automatic test_reset_stray();
      int w0;
      int d0;
      i_buf_gnt = 1'b1;
      start_layer(12'h010, 8'd3, 8'd2, 12'h020);
      beat(DW'(8'hD1));
      beat(DW'(8'hD2));
      rst = 1'b1;
      step();
      rst = 1'b0;
      nchk++; if ({o_buf_wr_en, o_busy, o_done, o_overflow, o_err_stray} !== 5'b0 || o_buf_addr !== '0 || o_buf_wdata !== '0)
         $display("FAIL rst_mid: got %b/%h expected 00000/000", {o_buf_wr_en, o_busy, o_done, o_overflow, o_err_stray}, o_buf_addr); else npass++;
      w0 = wa_q.size();
      d0 = done_cnt;
      for (int k = 0; k < 10; k++) step();
      nchk++; if (done_cnt != d0 || wa_q.size() != w0)
         $display("FAIL rst_quiet: got done %0d writes %0d expected 0 0", done_cnt - d0, wa_q.size() - w0); else npass++;
      beat(DW'(8'hEE));
      nchk++; if (o_err_stray !== 1'b1) $display("FAIL stray_set: got %b expected 1", o_err_stray); else npass++;
      step();
      nchk++; if (wa_q.size() != w0) $display("FAIL stray_write: got %0d expected 0", wa_q.size() - w0); else npass++;
      start_layer(12'h010, 8'd3, 8'd2, 12'h020);
      nchk++; if (o_err_stray !== 1'b0) $display("FAIL stray_clear: got %b expected 0", o_err_stray); else npass++;
      do_reset();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_contention();
      test_overflow();
      test_zero();
      test_wrap();
      test_reset_stray();
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
